// File: rtl/instr_sequencer.sv
// instr_sequencer: program sequencer for the 9-bit processor.
// Fetches instructions from a synchronous instruction memory (one-cycle read
// latency), drives the processor's DIN/Run, supplies the immediate word for
// mvi, waits for Done between instructions, and reports halt, a Done
// watchdog error and the count of retired instructions.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous active-high reset
//   Start      in   begins execution (sampled only in IDLE)
//   MemData    in   instruction memory read data (valid cycle after MemAddr)
//   MemAddr    out  instruction memory address
//   Done       in   processor Done pulse
//   DIN        out  processor instruction/immediate bus
//   Run        out  processor Run
//   PC         out  program counter
//   Busy       out  high in FETCH/ISSUE/IMM/WAIT
//   Halted     out  high in HALTED
//   Error      out  high in ERROR (Done watchdog expired)
//   InstrCount out  instructions retired (Done seen in WAIT)
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [8:0]        MemData,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              Done,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [CNT_W-1:0]  InstrCount
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic [ADDR_W-1:0] pc_plus1;
  logic [TW-1:0]     tcnt_inc;
  logic [2:0]        opcode;

  // Address arithmetic wraps modulo 2^ADDR_W, so an mvi in the last word
  // fetches its immediate from address 0.
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign tcnt_inc = tcnt_q + TW'(1);
  assign opcode   = MemData[8:6];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    tcnt_d  = '0;
    MemAddr = pc_q;
    DIN     = '0;
    Run     = 1'b0;
    Busy    = 1'b0;
    Halted  = 1'b0;
    Error   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_FETCH;
      end
      S_FETCH: begin
        Busy    = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        Busy    = 1'b1;
        DIN     = MemData;
        MemAddr = pc_plus1;
        if (opcode == 3'b111) begin
          state_d = S_HALTED;
        end else begin
          Run     = 1'b1;
          pc_d    = pc_plus1;
          state_d = (opcode == 3'b001) ? S_IMM : S_WAIT;
        end
      end
      S_IMM: begin
        Busy    = 1'b1;
        DIN     = MemData;
        MemAddr = pc_plus1;
        pc_d    = pc_plus1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // MemAddr holds PC here, so the next instruction word is already on
        // MemData when Done sends us back to ISSUE.
        Busy = 1'b1;
        if (Done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_ISSUE;
        end else if (tcnt_inc == TW'(TIMEOUT)) begin
          state_d = S_ERROR;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      S_HALTED: Halted = 1'b1;
      S_ERROR:  Error  = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  assign PC         = pc_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [8:0] MemData = '0;
  logic [4:0] MemAddr;
  logic       Done;
  logic [8:0] DIN;
  logic       Run;
  logic [4:0] PC;
  logic       Busy, Halted, Error;
  logic [7:0] InstrCount;

  // Second instance with a 2-bit address space for wrap-around checks.
  logic       Start2 = 1'b0;
  logic [8:0] MemData2 = '0;
  logic [1:0] MemAddr2;
  logic       Done2;
  logic [8:0] DIN2;
  logic       Run2;
  logic [1:0] PC2;
  logic       Busy2, Halted2, Error2;
  logic [7:0] InstrCount2;

  instr_sequencer #(.ADDR_W(5), .TIMEOUT(15), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .MemData(MemData),
    .MemAddr(MemAddr), .Done(Done), .DIN(DIN), .Run(Run), .PC(PC),
    .Busy(Busy), .Halted(Halted), .Error(Error), .InstrCount(InstrCount)
  );

  instr_sequencer #(.ADDR_W(2), .TIMEOUT(15), .CNT_W(8)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start(Start2), .MemData(MemData2),
    .MemAddr(MemAddr2), .Done(Done2), .DIN(DIN2), .Run(Run2), .PC(PC2),
    .Busy(Busy2), .Halted(Halted2), .Error(Error2), .InstrCount(InstrCount2)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [8:0] mem  [0:31];
  logic [8:0] mem2 [0:3];
  always @(posedge Clock) MemData  <= mem[MemAddr];
  always @(posedge Clock) MemData2 <= mem2[MemAddr2];

  // Second instance: Done in any busy cycle with Run low and DIN zero
  // (i.e. one-cycle WAIT); FETCH also matches but Done is ignored there.
  assign Done2 = Busy2 && !Run2 && (DIN2 == 9'd0);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Processor model: latches the instruction on a Run cycle, then raises Done
  // in its last step (mv/mvi: 2nd cycle after PRE, add/sub: 4th).
  logic [8:0] R [0:7];
  logic [8:0] ir = '0;
  logic [8:0] imm = '0;
  int         step = 0;
  logic       done_model = 1'b0;
  logic       proc_en = 1'b1;
  logic       spur = 1'b0;
  assign Done = (proc_en & done_model) | spur;

  function automatic int done_step(input logic [8:0] w);
    return (w[8:6] == 3'b010 || w[8:6] == 3'b011) ? 4 : 2;
  endfunction

  initial for (int i = 0; i < 8; i++) R[i] = '0;

  always @(negedge Clock) begin
    if (Reset) begin
      step       <= 0;
      done_model <= 1'b0;
    end else if (step == 0) begin
      done_model <= 1'b0;
      if (Run) begin
        ir   <= DIN;
        step <= 1;
      end
    end else begin
      if (step == 1 && ir[8:6] == 3'b001) imm <= DIN;
      if (step == done_step(ir)) begin
        done_model <= 1'b1;
        step       <= 0;
        case (ir[8:6])
          3'b000: R[ir[5:3]] <= R[ir[2:0]];
          3'b001: R[ir[5:3]] <= imm;
          3'b010: R[ir[5:3]] <= R[ir[5:3]] + R[ir[2:0]];
          3'b011: R[ir[5:3]] <= R[ir[5:3]] - R[ir[2:0]];
          default: ;
        endcase
      end else begin
        done_model <= 1'b0;
        step       <= step + 1;
      end
    end
  end

  // Scoreboard: every cycle where the sequencer drives Run or a nonzero DIN
  // must match the next expected {cycle, Run, DIN}.
  typedef struct {
    int         cyc;
    logic       run;
    logic [8:0] din;
  } ev_t;
  ev_t sb[$];
  ev_t ev;

  always @(negedge Clock) begin
    if (!Reset && (Run || DIN != 9'd0)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got Run=%0b DIN=%o expected no activity (cycle %0d)", Run, DIN, cyc);
      end else begin
        ev = sb.pop_front();
        check("issue_cycle", 32'(cyc), 32'(ev.cyc));
        check("issue_run", 32'(Run), 32'(ev.run));
        check("issue_din", 32'(DIN), 32'(ev.din));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  task automatic goto(input int c);
    if (cyc > c) check("schedule", 32'(cyc), 32'(c));
    while (cyc < c) tick(1);
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    Start  = 1'b0;
    Start2 = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  int t0;

  initial begin
    clear_mem();
    mem2[0] = 9'o007;  // mv R0,R7 (also the wrapped immediate)
    mem2[1] = 9'o000;
    mem2[2] = 9'o000;
    mem2[3] = 9'o100;  // mvi R0 at the last address
    tick(2);
    check("rst_run", 32'(Run), 0);
    check("rst_din", 32'(DIN), 0);
    check("rst_flags", 32'({Busy, Halted, Error}), 0);
    check("rst_pc", 32'(PC), 0);
    check("rst_memaddr", 32'(MemAddr), 0);
    check("rst_count", 32'(InstrCount), 0);
    Reset = 1'b0;
    tick(1);

    // mvi R0,5 ; mv R1,R0 ; halt
    mem[0] = 9'o100; mem[1] = 9'd5; mem[2] = 9'o010; mem[3] = 9'o700;
    Start = 1'b1;
    t0 = cyc;
    sb.push_back('{t0 + 2, 1'b1, 9'o100});
    sb.push_back('{t0 + 3, 1'b0, 9'd5});
    sb.push_back('{t0 + 5, 1'b1, 9'o010});
    sb.push_back('{t0 + 8, 1'b0, 9'o700});
    tick(1);
    Start = 1'b0;
    goto(t0 + 9);
    check("t1_halted", 32'(Halted), 1);
    check("t1_busy", 32'(Busy), 0);
    check("t1_pc", 32'(PC), 3);
    check("t1_count", 32'(InstrCount), 2);
    check("t1_r0", 32'(R[0]), 5);
    check("t1_r1", 32'(R[1]), 5);

    // add R0,R1 ; halt
    do_reset();
    clear_mem();
    mem[0] = 9'o201; mem[1] = 9'o700;
    Start = 1'b1;
    t0 = cyc;
    sb.push_back('{t0 + 2, 1'b1, 9'o201});
    sb.push_back('{t0 + 7, 1'b0, 9'o700});
    goto(t0 + 6);
    check("t2_count_before", 32'(InstrCount), 0);
    goto(t0 + 7);
    check("t2_count_after", 32'(InstrCount), 1);
    goto(t0 + 8);
    check("t2_halted", 32'(Halted), 1);
    check("t2_pc", 32'(PC), 1);
    check("t2_r0", 32'(R[0]), 10);

    // Done withheld after mv R2,R0: watchdog fires after 15 WAIT cycles
    do_reset();
    clear_mem();
    mem[0] = 9'o020;
    proc_en = 1'b0;
    Start = 1'b1;
    t0 = cyc;
    sb.push_back('{t0 + 2, 1'b1, 9'o020});
    goto(t0 + 17);
    check("t3_err_early", 32'(Error), 0);
    check("t3_busy_early", 32'(Busy), 1);
    goto(t0 + 18);
    check("t3_err", 32'(Error), 1);
    check("t3_busy", 32'(Busy), 0);
    check("t3_run", 32'(Run), 0);
    tick(6);
    check("t3_err_sticky", 32'(Error), 1);
    check("t3_pc", 32'(PC), 1);
    check("t3_count", 32'(InstrCount), 0);
    proc_en = 1'b1;

    // ADDR_W=2: mvi at address 3, immediate from address 0
    do_reset();
    Start2 = 1'b1;
    t0 = cyc;
    tick(1);
    Start2 = 1'b0;
    goto(t0 + 8);
    check("t4_issue_pc", 32'(PC2), 3);
    check("t4_issue_run", 32'(Run2), 1);
    check("t4_issue_din", 32'(DIN2), 32'(9'o100));
    check("t4_issue_addr", 32'(MemAddr2), 0);
    goto(t0 + 9);
    check("t4_imm_din", 32'(DIN2), 7);
    check("t4_imm_run", 32'(Run2), 0);
    check("t4_imm_pc", 32'(PC2), 0);
    check("t4_imm_addr", 32'(MemAddr2), 1);
    goto(t0 + 10);
    check("t4_wait_pc", 32'(PC2), 1);
    check("t4_count", 32'(InstrCount2), 3);
    check("t4_flags", 32'({Halted2, Error2}), 0);

    // Reset during WAIT of an add, then re-run from address 0
    do_reset();
    clear_mem();
    mem[0] = 9'o201; mem[1] = 9'o700;
    Start = 1'b1;
    t0 = cyc;
    sb.push_back('{t0 + 2, 1'b1, 9'o201});
    tick(1);
    Start = 1'b0;
    goto(t0 + 4);
    Reset = 1'b1;
    #1;
    check("t5_run", 32'(Run), 0);
    check("t5_din", 32'(DIN), 0);
    check("t5_flags", 32'({Busy, Halted, Error}), 0);
    check("t5_pc", 32'(PC), 0);
    check("t5_memaddr", 32'(MemAddr), 0);
    check("t5_count", 32'(InstrCount), 0);
    tick(2);
    Reset = 1'b0;
    tick(1);
    Start = 1'b1;
    t0 = cyc;
    sb.push_back('{t0 + 2, 1'b1, 9'o201});
    sb.push_back('{t0 + 7, 1'b0, 9'o700});
    tick(1);
    Start = 1'b0;
    goto(t0 + 8);
    check("t5_halted", 32'(Halted), 1);
    check("t5_r0", 32'(R[0]), 15);
    check("t5_count_after", 32'(InstrCount), 1);

    // Spurious Done in IDLE and in IMM
    do_reset();
    clear_mem();
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    check("t6_idle_busy", 32'(Busy), 0);
    check("t6_idle_pc", 32'(PC), 0);
    check("t6_idle_count", 32'(InstrCount), 0);
    mem[0] = 9'o130; mem[1] = 9'd3; mem[2] = 9'o700;
    Start = 1'b1;
    t0 = cyc;
    sb.push_back('{t0 + 2, 1'b1, 9'o130});
    sb.push_back('{t0 + 3, 1'b0, 9'd3});
    sb.push_back('{t0 + 5, 1'b0, 9'o700});
    tick(1);
    Start = 1'b0;
    goto(t0 + 3);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    check("t6_wait_count", 32'(InstrCount), 0);
    goto(t0 + 6);
    check("t6_halted", 32'(Halted), 1);
    check("t6_count", 32'(InstrCount), 1);
    check("t6_pc", 32'(PC), 2);
    check("t6_r3", 32'(R[3]), 3);

    tick(2);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer that feeds the 9-bit processor from a synchronous instruction memory.
- Maintains the program counter and issues memory addresses.
- Drives the processor's DIN and Run inputs, inserting the immediate word for mvi, and waits on the processor's Done pulse before issuing the next instruction.
- Provides halt detection, a Done watchdog and an instruction counter for the top-level wrapper.

Parameters:
- ADDR_W, 5, width of program counter / memory address (program wraps modulo 2^ADDR_W).
- TIMEOUT, 15, maximum WAIT cycles allowed without Done before the error state.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; begins execution from IDLE.
- MemData  in  9  instruction memory read data, valid the cycle after MemAddr is presented.
- MemAddr  out  ADDR_W  instruction memory address.
- Done  in  1  processor Done (combinational, one cycle).
- DIN  out  9  processor instruction/immediate input.
- Run  out  1  processor Run.
- PC  out  ADDR_W  current program counter.
- Busy  out  1  high in FETCH/ISSUE/IMM/WAIT.
- Halted  out  1  high in HALTED.
- Error  out  1  high in ERROR.
- InstrCount  out  CNT_W  instructions retired (Done pulses seen in WAIT).

Behaviour:
- Opcode field is word bits [8:6]: 000 mv, 001 mvi, 010 add, 011 sub, 111 halt. Opcodes 100-110 are treated as single-word instructions.
- Reset (async, any state, mid-instruction included):
  - state=IDLE, PC=0, InstrCount=0, timeout counter=0.
  - DIN=0, Run=0, Busy=Halted=Error=0.
  - MemAddr=0.
- Run and DIN are combinational from state and MemData. MemAddr is combinational from state and PC. PC, InstrCount and the timeout counter are registers.
- IDLE: MemAddr=PC, Run=0, DIN=0. Start=1 -> FETCH.
- FETCH (1 cycle): MemAddr=PC -> ISSUE.
- ISSUE (coincides with processor PRE):
  - DIN=MemData, MemAddr=PC+1.
  - Opcode 111: Run=0, -> HALTED, PC unchanged.
  - Opcode 001: Run=1, PC<=PC+1, -> IMM.
  - Otherwise: Run=1, PC<=PC+1, -> WAIT.
- IMM (coincides with processor T0): DIN=MemData (immediate), Run=0, MemAddr=PC+1, PC<=PC+1, -> WAIT.
- WAIT:
  - Run=0, DIN=0, MemAddr=PC (prefetch of the next instruction). Timeout counter increments each cycle.
  - Done=1: InstrCount<=InstrCount+1 (wraps), counter cleared, -> ISSUE. The next instruction is issued the cycle after Done, matching the processor's return to PRE.
  - Counter reaching TIMEOUT without Done: -> ERROR.
- Done outside WAIT is ignored (not counted).
- HALTED and ERROR are sticky until Reset: Run=0, DIN=0, MemAddr=PC. Start is ignored.
- Start is sampled only in IDLE. Deasserting Start while running has no effect.
- PC wrap: PC=2^ADDR_W-1 increments to 0. MemAddr=PC+1 wraps identically. An mvi at the last address takes its immediate from address 0.
- Latency: Start -> first Run = 2 cycles (FETCH, ISSUE). Done -> next Run = 1 cycle.
- Throughput per instruction: mv = 3 cycles, mvi = 3, add/sub = 5, including ISSUE.

Test Plan:
- Program {mvi R0 @0=9'b001000000, imm @1=5, mv R1,R0 @2=9'b000001000, halt @3=9'b111000000}, Start pulse:
  - Run high at cycle 2 with DIN=0o100, then DIN=5 at cycle 3.
  - Processor R0=5, then R1=5.
  - Halted=1, PC=3, InstrCount=2.
- add R0,R1 with R0=5, R1=5, followed by halt:
  - Run high exactly one cycle after each Done; R0=10.
  - InstrCount=1 after add; Halted=1 at halt.
- Done held low by the bench after ISSUE of mv: Error=1 exactly TIMEOUT cycles after entering WAIT, Run stays 0, Start ignored.
- ADDR_W=2 with mvi at address 3 and immediate 7 at address 0: DIN=7 in IMM, PC wraps to 1 after IMM.
- Reset asserted while in WAIT mid add: all outputs return to reset values asynchronously, PC=0. After release, Start re-executes from address 0.
- Spurious Done pulse in IDLE and while in IMM: no state change, InstrCount unchanged.
